// File: rtl/avmm_led_pwm_pkg.sv
// Shared definitions for the Avalon-MM LED PWM/blink peripheral: register map,
// channel mode encoding and CHCFG field positions.
package avmm_led_pwm_pkg;

   localparam logic [4:0] ADDR_CTRL       = 5'd0;
   localparam logic [4:0] ADDR_DATA       = 5'd1;
   localparam logic [4:0] ADDR_PRESCALE   = 5'd2;
   localparam logic [4:0] ADDR_BLINK      = 5'd3;
   localparam logic [4:0] ADDR_IRQ        = 5'd5;
   localparam logic [4:0] ADDR_CHCFG_BASE = 5'd16;

   localparam int CHCFG_MODE_LSB = 8;
   localparam int CHCFG_MODE_MSB = 9;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_PWM    = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_RSVD   = 2'b11
   } led_mode_e;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: turns its mode, duty and static bit plus the shared PWM
// count and blink phase into a combinational drive level.
module led_pwm_channel
   import avmm_led_pwm_pkg::*;
#(
   parameter int DUTY_W = 8
) (
   input  led_mode_e         i_mode,
   input  logic [DUTY_W-1:0] i_duty,
   input  logic              i_static,
   input  logic [DUTY_W-1:0] i_pwm_cnt,
   input  logic              i_blink_phase,
   output logic              o_level
);

   logic w_pwm_on;

   // Strict compare: duty 0 never lights, maximum duty leaves one tick dark.
   assign w_pwm_on = (i_pwm_cnt < i_duty);

   always_comb begin
      o_level = 1'b0;
      case (i_mode)
         MODE_STATIC: o_level = i_static;
         MODE_PWM:    o_level = w_pwm_on;
         MODE_BLINK:  o_level = i_blink_phase && w_pwm_on;
         default:     o_level = 1'b0;
      endcase
   end

endmodule

// File: rtl/avmm_led_pwm_pio.sv
// Avalon-MM LED peripheral: NUM_CH channels, each static, PWM-dimmed or blinking
// from one shared prescaler/PWM/blink timebase. Define LED_PWM_IRQ_EN for the blink irq.
module avmm_led_pwm_pio
   import avmm_led_pwm_pkg::*;
#(
   parameter int NUM_CH  = 8,
   parameter int DUTY_W  = 8,
   parameter int PRESC_W = 16,
   parameter int BLINK_W = 8
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [4:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic [NUM_CH-1:0] led_external_connection_export
`ifdef LED_PWM_IRQ_EN
   ,
   output logic              irq
`endif
);

   logic                 r_ctrl_en;
   logic [NUM_CH-1:0]    r_data;
   logic [PRESC_W-1:0]   r_prescale;
   logic [BLINK_W-1:0]   r_blink;
   led_mode_e            r_mode [NUM_CH];
   logic [DUTY_W-1:0]    r_duty [NUM_CH];

   logic [PRESC_W-1:0]   r_presc_cnt;
   logic [DUTY_W-1:0]    r_pwm_cnt;
   logic [BLINK_W-1:0]   r_blink_cnt;
   logic                 r_blink_phase;

   logic [31:0]          r_readdata;
   logic [NUM_CH-1:0]    r_led;

   logic                 w_wr_ctrl;
   logic                 w_wr_data;
   logic                 w_wr_presc;
   logic                 w_wr_blink;
   logic                 w_tick;
   logic                 w_pwm_wrap;
   logic                 w_blink_toggle;
   logic [NUM_CH-1:0]    w_level;
   logic [31:0]          w_rdata;
   logic                 w_unused;

`ifdef LED_PWM_IRQ_EN
   logic                 r_irq_mask;
   logic                 r_irq_pending;
   logic                 r_irq;
   logic                 w_wr_irq;
`endif

   // Only the low field of each register is stored; the rest of the bus word is don't-care.
   assign w_unused = ^avs_writedata;

   assign w_wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
   assign w_wr_data  = avs_write && (avs_address == ADDR_DATA);
   assign w_wr_presc = avs_write && (avs_address == ADDR_PRESCALE);
   assign w_wr_blink = avs_write && (avs_address == ADDR_BLINK);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_ctrl_en  <= 1'b0;
         r_data     <= '0;
         r_prescale <= '0;
         r_blink    <= '0;
      end else begin
         if (w_wr_ctrl)  r_ctrl_en  <= avs_writedata[0];
         if (w_wr_data)  r_data     <= avs_writedata[NUM_CH-1:0];
         if (w_wr_presc) r_prescale <= avs_writedata[PRESC_W-1:0];
         if (w_wr_blink) r_blink    <= avs_writedata[BLINK_W-1:0];
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_mode[ch] <= MODE_STATIC;
            r_duty[ch] <= '0;
         end
      end else if (avs_write) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (avs_address == ADDR_CHCFG_BASE + 5'(ch)) begin
               r_mode[ch] <= led_mode_e'(avs_writedata[CHCFG_MODE_MSB:CHCFG_MODE_LSB]);
               r_duty[ch] <= avs_writedata[DUTY_W-1:0];
            end
         end
      end
   end

   assign w_tick     = (r_presc_cnt == r_prescale);
   assign w_pwm_wrap = w_tick && (r_pwm_cnt == '1);
   // A BLINK write restarts the blink count and suppresses a toggle on that edge.
   assign w_blink_toggle = w_pwm_wrap && (r_blink_cnt == r_blink) && !w_wr_blink;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_presc_cnt   <= '0;
         r_pwm_cnt     <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else begin
         if (w_wr_presc || w_tick) r_presc_cnt <= '0;
         else                      r_presc_cnt <= r_presc_cnt + 1'b1;

         if (w_tick) r_pwm_cnt <= r_pwm_cnt + 1'b1;

         if (w_wr_blink || w_blink_toggle) r_blink_cnt <= '0;
         else if (w_pwm_wrap)              r_blink_cnt <= r_blink_cnt + 1'b1;

         if (w_blink_toggle) r_blink_phase <= ~r_blink_phase;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         led_pwm_channel #(
            .DUTY_W(DUTY_W)
         ) u_channel (
            .i_mode        (r_mode[gi]),
            .i_duty        (r_duty[gi]),
            .i_static      (r_data[gi]),
            .i_pwm_cnt     (r_pwm_cnt),
            .i_blink_phase (r_blink_phase),
            .o_level       (w_level[gi])
         );
      end
   endgenerate

`ifdef LED_PWM_IRQ_EN
   assign w_wr_irq = avs_write && (avs_address == ADDR_IRQ);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_irq_mask    <= 1'b0;
         r_irq_pending <= 1'b0;
         r_irq         <= 1'b0;
      end else begin
         if (w_wr_irq) r_irq_mask <= avs_writedata[0];
         // A new toggle wins over a simultaneous write-1-to-clear.
         if (w_blink_toggle)                      r_irq_pending <= 1'b1;
         else if (w_wr_irq && avs_writedata[1])   r_irq_pending <= 1'b0;
         r_irq <= r_irq_mask && r_irq_pending;
      end
   end

   assign irq = r_irq;
`endif

   always_comb begin
      w_rdata = '0;
      case (avs_address)
         ADDR_CTRL:     w_rdata = 32'(r_ctrl_en);
         ADDR_DATA:     w_rdata = 32'(r_data);
         ADDR_PRESCALE: w_rdata = 32'(r_prescale);
         ADDR_BLINK:    w_rdata = 32'(r_blink);
`ifdef LED_PWM_IRQ_EN
         ADDR_IRQ:      w_rdata = {30'd0, r_irq_pending, r_irq_mask};
`endif
         default:       w_rdata = '0;
      endcase
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (avs_address == ADDR_CHCFG_BASE + 5'(ch)) begin
            w_rdata = 32'(r_duty[ch]) | (32'(r_mode[ch]) << CHCFG_MODE_LSB);
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_readdata <= '0;
         r_led      <= '0;
      end else begin
         if (avs_read) r_readdata <= w_rdata;
         r_led <= r_ctrl_en ? w_level : '0;
      end
   end

   assign avs_readdata                   = r_readdata;
   assign led_external_connection_export = r_led;

endmodule

// File: tb/tb_avmm_led_pwm_pio.sv
// Self-checking bench for avmm_led_pwm_pio: a cycle-level arithmetic model of the
// register map and timebase, a per-cycle compare, and directed literal checks.
module tb_avmm_led_pwm_pio;

   localparam int NUM_CH     = 8;
   localparam int DUTY_W     = 8;
   localparam int PRESC_W    = 16;
   localparam int BLINK_W    = 8;
   localparam int PWM_PERIOD = 1 << DUTY_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [4:0]        avs_address = '0;
   logic              avs_read = 1'b0;
   logic              avs_write = 1'b0;
   logic [31:0]       avs_writedata = '0;
   logic [31:0]       avs_readdata;
   logic [NUM_CH-1:0] led;
`ifdef LED_PWM_IRQ_EN
   logic              irq;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;
   int cyc = 0;

   avmm_led_pwm_pio #(
      .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PRESC_W(PRESC_W), .BLINK_W(BLINK_W)
   ) dut (
      .clk_clk                        (clk),
      .reset_reset_n                  (rst_n),
      .avs_address                    (avs_address),
      .avs_read                       (avs_read),
      .avs_write                      (avs_write),
      .avs_writedata                  (avs_writedata),
      .avs_readdata                   (avs_readdata),
      .led_external_connection_export (led)
`ifdef LED_PWM_IRQ_EN
      ,
      .irq                            (irq)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // ---------------- behavioural model ----------------
   bit                m_ctrl = 0;
   logic [NUM_CH-1:0] m_data = '0;
   int                m_presc = 0;
   int                m_blink = 0;
   int                m_mode [NUM_CH];
   int                m_duty [NUM_CH];
   int                m_pcyc = 0;     // cycles since the prescaler was last cleared
   int                m_ticks = 0;    // ticks since reset; pwm count is this mod period
   int                m_nwrap = 0;    // pwm wraps since last blink restart/toggle
   bit                m_phase = 0;
   bit                m_mask = 0;
   bit                m_pend = 0;
   logic [NUM_CH-1:0] m_exp_led = '0;
   logic [31:0]       m_exp_rd = '0;
   bit                m_exp_irq = 0;

   function automatic bit chan_level(input int mode, input int duty, input bit s,
                                     input int pcnt, input bit ph);
      bit r;
      case (mode)
         0:       r = s;
         1:       r = (pcnt < duty);
         2:       r = ph && (pcnt < duty);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] model_read(input int a);
      logic [31:0] r;
      r = '0;
      if (a == 0)      r = 32'(m_ctrl);
      else if (a == 1) r = 32'(m_data);
      else if (a == 2) r = 32'(m_presc);
      else if (a == 3) r = 32'(m_blink);
`ifdef LED_PWM_IRQ_EN
      else if (a == 5) r = 32'(m_pend) * 2 + 32'(m_mask);
`endif
      else if (a >= 16 && a < 16 + NUM_CH) r = 32'(m_mode[a-16] * 256 + m_duty[a-16]);
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int p, pcnt, nw, a;
      bit tick, wrap, tog;
      logic [NUM_CH-1:0] vec;
      logic [31:0] wd;
      if (!rst_n) begin
         m_ctrl <= 0; m_data <= '0; m_presc <= 0; m_blink <= 0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            m_mode[ch] <= 0;
            m_duty[ch] <= 0;
         end
         m_pcyc <= 0; m_ticks <= 0; m_nwrap <= 0; m_phase <= 0;
         m_mask <= 0; m_pend <= 0;
         m_exp_led <= '0; m_exp_rd <= '0; m_exp_irq <= 0;
      end else begin
         a  = int'(avs_address);
         wd = avs_writedata;
         p    = m_presc;
         tick = (m_pcyc % (p + 1)) == p;
         pcnt = m_ticks % PWM_PERIOD;
         wrap = tick && (pcnt == PWM_PERIOD - 1);
         for (int ch = 0; ch < NUM_CH; ch++)
            vec[ch] = chan_level(m_mode[ch], m_duty[ch], m_data[ch], pcnt, m_phase);
         m_exp_led <= m_ctrl ? vec : '0;
         if (avs_read) m_exp_rd <= model_read(a);
         m_exp_irq <= m_mask && m_pend;

         m_ticks <= m_ticks + int'(tick);
         m_pcyc  <= (avs_write && a == 2) ? 0 : m_pcyc + 1;
         nw  = m_nwrap;
         tog = 0;
         if (avs_write && a == 3) nw = 0;
         else if (wrap) begin
            nw = nw + 1;
            if (nw > m_blink) begin
               nw  = 0;
               tog = 1;
            end
         end
         m_nwrap <= nw;
         if (tog) m_phase <= ~m_phase;
         if (tog) m_pend <= 1'b1;
         else if (avs_write && a == 5 && wd[1]) m_pend <= 1'b0;

         if (avs_write) begin
            if (a == 0)      m_ctrl  <= wd[0];
            else if (a == 1) m_data  <= wd[NUM_CH-1:0];
            else if (a == 2) m_presc <= int'(wd[PRESC_W-1:0]);
            else if (a == 3) m_blink <= int'(wd[BLINK_W-1:0]);
`ifdef LED_PWM_IRQ_EN
            else if (a == 5) m_mask  <= wd[0];
`endif
            else if (a >= 16 && a < 16 + NUM_CH) begin
               m_mode[a-16] <= int'(wd[9:8]);
               m_duty[a-16] <= int'(wd[DUTY_W-1:0]);
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         chk("model_export", 32'(led), 32'(m_exp_led));
         chk("model_readdata", avs_readdata, m_exp_rd);
`ifdef LED_PWM_IRQ_EN
         chk("model_irq", 32'(irq), 32'(m_exp_irq));
`endif
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      avs_address = addr; avs_writedata = data; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
      $display("WR  addr=%0d data=0x%08h", addr, data);
   endtask

   task automatic rd_chk(input logic [4:0] addr, input logic [31:0] exp, input string name);
      avs_address = addr; avs_read = 1'b1;
      @(negedge clk);
      avs_read = 1'b0;
      $display("RD  addr=%0d data=0x%08h", addr, avs_readdata);
      chk(name, avs_readdata, exp);
   endtask

   task automatic count_high(input int idx, input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         cnt += int'(led[idx]);
      end
      $display("CNT led[%0d] high %0d of %0d cycles", idx, cnt, n);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic wr_at(input int n, input logic [4:0] addr, input logic [31:0] data);
      chk("wr_at_schedule", 32'(cyc < n), 32'd1);
      while (cyc < n - 1) @(negedge clk);
      wr(addr, data);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cnt;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);
      chk("reset_export", 32'(led), 32'h0);
      chk("reset_readdata", avs_readdata, 32'h0);
      for (int a = 0; a < 32; a++) rd_chk(5'(a), 32'h0, $sformatf("reset_reg%0d", a));

      // STATIC
      wr(5'd0, 32'h1);
      wr(5'd1, 32'hA5);
      chk("static_not_yet", 32'(led), 32'h00);
      @(negedge clk);
      chk("static_a5", 32'(led), 32'hA5);
      rd_chk(5'd1, 32'hA5, "data_readback");
      wr(5'd0, 32'h0);
      @(negedge clk);
      chk("ctrl_off", 32'(led), 32'h00);

      // read and write same address on one edge returns the old value
      avs_address = 5'd1; avs_writedata = 32'h3C; avs_read = 1'b1; avs_write = 1'b1;
      @(negedge clk);
      avs_read = 1'b0; avs_write = 1'b0;
      chk("rw_same_old", avs_readdata, 32'hA5);
      rd_chk(5'd1, 32'h3C, "rw_same_new");

      // PWM, PRESCALE = 0
      wr(5'd1, 32'h0);
      wr(5'd0, 32'h1);
      wr(5'd16, 32'h140);
      repeat (2) @(negedge clk);
      count_high(0, 256, cnt);
      chk("pwm_duty64", 32'(cnt), 32'd64);
      wr(5'd16, 32'h100);
      repeat (2) @(negedge clk);
      count_high(0, 256, cnt);
      chk("pwm_duty0", 32'(cnt), 32'd0);
      wr(5'd16, 32'h1FF);
      repeat (2) @(negedge clk);
      count_high(0, 256, cnt);
      chk("pwm_duty255", 32'(cnt), 32'd255);
      wr(5'd16, 32'h3FF);
      repeat (2) @(negedge clk);
      count_high(0, 256, cnt);
      chk("mode_reserved", 32'(cnt), 32'd0);
      rd_chk(5'd16, 32'h3FF, "chcfg0_readback");

      // Prescaler
      wr(5'd2, 32'h3);
      wr(5'd16, 32'h180);
      repeat (2) @(negedge clk);
      count_high(0, 1024, cnt);
      chk("presc3_duty128", 32'(cnt), 32'd512);
      repeat (3) @(negedge clk);
      wr(5'd2, 32'h3);
      repeat (2) @(negedge clk);
      count_high(0, 1024, cnt);
      chk("presc_rewrite", 32'(cnt), 32'd512);
      rd_chk(5'd2, 32'h3, "presc_readback");

      // BLINK
      wr(5'd16, 32'h0);
      wr(5'd2, 32'h0);
      wr(5'd3, 32'h1);
      wr(5'd19, 32'h2FF);
      repeat (600) @(negedge clk);
      count_high(3, 1024, cnt);
      chk("blink_duty255", 32'(cnt), 32'd510);
      rd_chk(5'd19, 32'h2FF, "chcfg3_readback");

      // Asynchronous reset mid-blink
      wr(5'd1, 32'h2);
      repeat (2) @(negedge clk);
      chk("pre_reset_led1", 32'(led[1]), 32'h1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_export", 32'(led), 32'h0);
      chk("async_reset_readdata", avs_readdata, 32'h0);
      cmp_en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      rd_chk(5'd0, 32'h0, "post_reset_ctrl");
      rd_chk(5'd1, 32'h0, "post_reset_data");
      rd_chk(5'd3, 32'h0, "post_reset_blink");
      rd_chk(5'd19, 32'h0, "post_reset_chcfg3");

`ifdef LED_PWM_IRQ_EN
      // BLINK=0, PRESCALE=0: blink toggles at cycles 256, 512, ...
      wr_at(40, 5'd5, 32'h1);
      wait_cyc(256);
      chk("irq_before_toggle", 32'(irq), 32'h0);
      wait_cyc(257);
      chk("irq_after_toggle", 32'(irq), 32'h1);
      rd_chk(5'd5, 32'h3, "irq_reg_pending");
      wr_at(300, 5'd5, 32'h3);
      wait_cyc(301);
      chk("irq_cleared", 32'(irq), 32'h0);
      wr_at(512, 5'd5, 32'h3);
      wait_cyc(513);
      chk("irq_clear_vs_toggle", 32'(irq), 32'h1);
      rd_chk(5'd5, 32'h3, "irq_reg_kept");
`else
      wr(5'd5, 32'h3);
      rd_chk(5'd5, 32'h0, "irq_addr_absent");
`endif

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
